// File: rtl/demux_seq_pkg.sv
// Shared constants and state type for the round-robin demux sequencer.
package demux_seq_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/demux_next_ch.sv
// Combinational channel finder: nearest enabled channel above cur, lowest
// enabled channel, and whether cur is the highest enabled channel.
module demux_next_ch
  import demux_seq_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  nxt,
  output logic [SEL_W-1:0]  first,
  output logic              last
);

  // Descending scans so the last hit is the lowest qualifying index.
  always_comb begin
    nxt   = '0;
    first = '0;
    last  = 1'b1;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first = SEL_W'(i);
        if (i > int'(cur)) begin
          nxt  = SEL_W'(i);
          last = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/demux_rr_sequencer.sv
// Round-robin sequencer driving in/sel of a 1:8 demux, with per-channel
// dwell and channel/frame completion strobes.
module demux_rr_sequencer #(
  parameter int unsigned NUM_CH  = 8,
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [NUM_CH-1:0]  en_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               data_in,
  output logic               in,
  output logic [2:0]         sel,
  output logic               busy,
  output logic               ch_done,
  output logic               frame_done
);

  import demux_seq_pkg::*;

  seq_state_t          state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;

  logic [SEL_W-1:0]    run_nxt;
  logic                run_last;
  logic [SEL_W-1:0]    live_first;
  logic [SEL_W-1:0]    unused_run_first;
  logic [SEL_W-1:0]    unused_live_nxt;
  logic                unused_live_last;

  // Advance path works on the latched mask; frame-start path on the live mask.
  demux_next_ch u_adv (
    .mask  (mask_q),
    .cur   (sel_q),
    .nxt   (run_nxt),
    .first (unused_run_first),
    .last  (run_last)
  );

  demux_next_ch u_start (
    .mask  (en_mask),
    .cur   (SEL_W'(0)),
    .nxt   (unused_live_nxt),
    .first (live_first),
    .last  (unused_live_last)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    unique case (state_q)
      IDLE: begin
        if (start && !stop && (en_mask != '0)) begin
          mask_d  = en_mask;
          dwell_d = dwell;
          sel_d   = live_first;
          cnt_d   = dwell;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          sel_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (!run_last) begin
          sel_d = run_nxt;
          cnt_d = dwell_q;
        end else if (continuous && (en_mask != '0)) begin
          // Back-to-back frame: re-latch settings with no gap cycle.
          mask_d  = en_mask;
          dwell_d = dwell;
          sel_d   = live_first;
          cnt_d   = dwell;
        end else begin
          state_d = IDLE;
          sel_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign sel        = sel_q;
  assign in         = data_in & busy;
  assign ch_done    = busy && (cnt_q == '0) && !stop;
  assign frame_done = ch_done && run_last;

endmodule

// File: tb/tb_demux_rr_sequencer.sv
// Scoreboard bench: a slot-schedule model predicts each cycle's outputs,
// a negedge monitor compares them against the DUT and a behavioural demux.
module tb_demux_rr_sequencer;

  localparam int unsigned DW = 4;

  logic          clk = 1'b0;
  logic          rst, start, stop, continuous, data_in;
  logic [7:0]    en_mask;
  logic [DW-1:0] dwell;
  logic          in_s;
  logic [2:0]    sel;
  logic          busy, ch_done, frame_done;
  logic [7:0]    y;

  always #5 clk = ~clk;

  demux_rr_sequencer #(.NUM_CH(8), .DWELL_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .en_mask    (en_mask),
    .dwell      (dwell),
    .data_in    (data_in),
    .in         (in_s),
    .sel        (sel),
    .busy       (busy),
    .ch_done    (ch_done),
    .frame_done (frame_done)
  );

  // Behavioural 1:8 demux downstream of the sequencer.
  always_comb begin
    y = '0;
    y[sel] = in_s;
  end

  typedef struct {
    logic       busy;
    logic [2:0] sel;
    logic       ch_done;
    logic       frame_done;
    logic       in_b;
    logic [7:0] y;
  } exp_t;

  typedef struct {
    logic [2:0] ch;
    logic       cd;
    logic       fd;
  } slot_t;

  slot_t sched[$];
  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp_v);
    end
  endtask

  // One slot per cycle of the frame, channels ascending, dwell+1 slots each.
  task automatic build_frame(input logic [7:0] m, input logic [DW-1:0] dw);
    int hi = 0;
    for (int c = 0; c < 8; c++) if (m[c]) hi = c;
    for (int c = 0; c < 8; c++) begin
      if (m[c]) begin
        for (int k = 0; k <= int'(dw); k++) begin
          slot_t s;
          s.ch = 3'(c);
          s.cd = (k == int'(dw));
          s.fd = (k == int'(dw)) && (c == hi);
          sched.push_back(s);
        end
      end
    end
  endtask

  task automatic step();
    exp_t  e;
    slot_t h;
    h.ch = '0; h.cd = 1'b0; h.fd = 1'b0;
    e.busy = (sched.size() != 0);
    if (e.busy) h = sched[0];
    e.sel        = e.busy ? h.ch : 3'd0;
    e.ch_done    = e.busy && h.cd && !stop;
    e.frame_done = e.busy && h.fd && !stop;
    e.in_b       = data_in & e.busy;
    e.y          = e.in_b ? (8'd1 << e.sel) : 8'd0;
    sb.push_back(e);
    @(posedge clk);
    if (rst) begin
      sched.delete();
    end else if (sched.size() != 0) begin
      if (stop) begin
        sched.delete();
      end else begin
        h = sched.pop_front();
        if (h.fd && continuous && (en_mask != 8'd0)) build_frame(en_mask, dwell);
      end
    end else if (start && !stop && (en_mask != 8'd0)) begin
      build_frame(en_mask, dwell);
    end
    cyc++;
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("busy",       8'(busy),       8'(e.busy));
      chk("sel",        8'(sel),        8'(e.sel));
      chk("ch_done",    8'(ch_done),    8'(e.ch_done));
      chk("frame_done", 8'(frame_done), 8'(e.frame_done));
      chk("in",         8'(in_s),       8'(e.in_b));
      chk("demux_y",    y,              e.y);
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    en_mask = '0; dwell = '0; data_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 1'b0;

    // Single frame A5, dwell 2.
    en_mask = 8'hA5; dwell = 4'd2; start = 1'b1; data_in = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin data_in = 1'($urandom); step(); end

    // Continuous 81 dwell 0, then mask change mid-frame.
    en_mask = 8'h81; dwell = 4'd0; continuous = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    en_mask = 8'h10;
    repeat (6) step();
    continuous = 1'b0;
    repeat (3) step();

    // Zero mask start is ignored; then full mask with dwell 0.
    en_mask = 8'h00; data_in = 1'b1; start = 1'b1;
    repeat (2) step();
    en_mask = 8'hFF; dwell = 4'd0;
    step();
    start = 1'b0;
    repeat (9) step();

    // Abort on channel 2's last dwell cycle, then start+stop in IDLE.
    en_mask = 8'hA5; dwell = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (2) step();
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    repeat (2) step();

    // Reset mid-frame with long dwell, then fresh frame.
    en_mask = 8'hFF; dwell = 4'd15; start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    rst = 1'b1;
    step();
    rst = 1'b0; en_mask = 8'h28; dwell = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      start      = ($urandom_range(0, 7) == 0);
      stop       = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) continuous = 1'($urandom);
      if ($urandom_range(0, 9) == 0)
        en_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 9) == 0)
        dwell = ($urandom_range(0, 9) == 0) ? 4'd15 : DW'($urandom_range(0, 3));
      data_in = 1'($urandom);
      step();
    end

    rst = 1'b0; start = 1'b0; stop = 1'b1; continuous = 1'b0;
    repeat (2) step();
    stop = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_rr_sequencer.md
# demux_rr_sequencer

Round-robin channel sequencer that drives the `in`/`sel` inputs of the 1:8 behavioural demux. It walks through the enabled output channels in ascending index order. Each enabled channel is held for a programmable dwell time, and the serial input bit is gated through only while the sequencer is running. The block sits directly upstream of the demux and produces per-channel and per-frame completion strobes for the control logic.

## Interface
Parameters:
- `NUM_CH`, default 8: number of demux channels. The block is fixed at 8 because `sel` is 3 bits wide.
- `DWELL_W`, default 4: width of the dwell-count field.

Ports (single clock; reset is synchronous and active-high):
- `clk` — input, 1 bit: the only clock. All state changes on its rising edge.
- `rst` — input, 1 bit: synchronous, active-high reset.
- `start` — input, 1 bit: single-cycle request to begin a frame.
- `stop` — input, 1 bit: synchronous abort.
- `continuous` — input, 1 bit: when 1, frames repeat automatically.
- `en_mask` — input, 8 bits: channel enable mask. Bit i enables channel i.
- `dwell` — input, `DWELL_W` bits: each channel is held for `dwell`+1 cycles.
- `data_in` — input, 1 bit: serial data to be routed.
- `in` — output, 1 bit: data to the demux. Equals `data_in` while `busy`, otherwise 0.
- `sel` — output, 3 bits: channel select to the demux.
- `busy` — output, 1 bit: high while the FSM is in RUN.
- `ch_done` — output, 1 bit: high during the last dwell cycle of each channel.
- `frame_done` — output, 1 bit: high during the last dwell cycle of the highest enabled channel.

## Operation
- FSM has two states: IDLE and RUN. Registers are `state`, `sel`, `cnt` (`DWELL_W` bits), `mask_q` (8 bits) and `dwell_q`.
- Reset values: `state`=IDLE, `sel`=0, `cnt`=0, `mask_q`=0, `dwell_q`=0. Consequently `in`=0, `busy`=0, `ch_done`=0 and `frame_done`=0.
- IDLE, with `start`=1, `stop`=0 and `en_mask`≠0:
  - Latch `mask_q`←`en_mask` and `dwell_q`←`dwell`.
  - Set `sel` to the lowest set bit of `en_mask` and `cnt`←`dwell`.
  - Go to RUN.
- IDLE, with `start` and `en_mask`=0: ignored, FSM stays in IDLE.
- RUN, with `cnt`≠0: `cnt` decrements; `sel` holds.
- RUN, with `cnt`=0: `ch_done`=1. Then:
  - If `mask_q` has a set bit above `sel`, `sel` moves to the nearest such bit and `cnt`←`dwell_q`.
  - Otherwise `frame_done`=1 in the same cycle, and:
    - If `continuous`=1 and `en_mask`≠0: re-latch `mask_q`/`dwell_q` from the live inputs, set `sel` to the lowest set bit and stay in RUN with no gap cycle.
    - Otherwise go to IDLE and `sel`←0.
- `stop` in RUN: next state is IDLE with `sel`←0 and `cnt`←0. No `ch_done` or `frame_done` is generated for the aborted channel, even if `cnt`=0 in that cycle.
- `stop` has priority over `start`. `start` while in RUN is ignored.
- Changes to `en_mask` or `dwell` during a frame have no effect until the next frame boundary.
- `in` is combinational: `data_in & busy`. No registering, so zero latency.
- `ch_done` and `frame_done` are decoded from registered state (`state`==RUN, `cnt`==0, `stop`=0).

## Timing
- Start latency: `start` sampled at edge N gives `busy`=1 and a valid `sel` from edge N+1.
- Cycles spent per enabled channel: `dwell`+1. A frame lasts k·(`dwell`+1) cycles, where k = popcount(`mask_q`).
- `dwell`=0: one cycle per channel, and `ch_done` stays high for every cycle of the frame.
- Single-bit mask: `ch_done` and `frame_done` coincide every frame.
- Channel-to-channel `sel` switch happens on the edge after `ch_done`, with no idle cycle in between.
- `rst` asserted mid-frame returns every register to its reset value at the next edge. `rst` overrides `stop` and `start`.

## Structure
- Package `demux_seq_pkg` holds:
  - `NUM_CH`=8 and `SEL_W`=3.
  - The state enum `seq_state_t` {IDLE, RUN}.
- Sub-module `demux_next_ch` is purely combinational. Inputs are `mask` and `cur`; outputs are `nxt[2:0]` (nearest set bit above `cur`), `first[2:0]` (lowest set bit) and `last` (no set bit above `cur`). It is used by both the frame-start path and the advance path.
- The demux itself is instantiated only in the test bench, connected after this block.

## Test plan
- Single frame: `en_mask`=8'hA5, `dwell`=2, `continuous`=0, `start` for one cycle.
  - `sel` must read 0,0,0,2,2,2,5,5,5,7,7,7.
  - `ch_done` must pulse in cycles 3, 6, 9 and 12.
  - `frame_done` must pulse in cycle 12, then the block returns to IDLE with `sel`=0.
  - Demux `y` must carry `data_in` only on bit `sel`.
- Continuous mode: `en_mask`=8'h81, `dwell`=0, `continuous`=1.
  - `sel` must toggle 0,7,0,7 with `frame_done` on every channel-7 cycle.
  - Changing the mask to 8'h10 mid-frame must take effect only after the next `frame_done`; `sel` then holds at 4.
- Zero mask and dwell=0: `start` with `en_mask`=0 → `busy` stays 0 and `in`=0 regardless of `data_in`.
  - `en_mask`=8'hFF, `dwell`=0 → `sel` counts 0..7 with `ch_done`=1 on all 8 cycles.
- Abort: `stop` during channel 2 with `cnt`=0 → no `ch_done`. Next cycle `busy`=0 and `sel`=0.
  - `start`+`stop` in the same cycle in IDLE → stays in IDLE.
- Reset: `rst` mid-frame with `dwell`=15 → all outputs at reset values on the next edge.
  - A following `start` must begin a fresh frame at the lowest enabled channel.
